mmcm_ps_servo: RTL and testbench

Parametrised phase-shift servo for the MMCM dynamic phase-shift port, running entirely in the PSCLK domain. It accepts signed phase-error samples from the upstream counter comparator, already synchronised into PSCLK, and smooths them with a power-of-two boxcar average. It then converts the average into a budget of PS steps using either bang-bang or proportional mode, and drives the MMCM `psen`/`psincdec`/`psdone` handshake with gap spacing and a timeout. It also tracks net phase position and lock status.

---
 rtl/mmcm_ps_servo.sv | 184 ++++++++++++++++++
 tb/tb_mmcm_ps_servo.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmcm_ps_servo.sv
// rtl/mmcm_ps_servo.sv - MMCM dynamic phase-shift servo: boxcar average, step budget, psen/psdone handshake
module mmcm_ps_servo #(
  parameter int ERR_W        = 32,
  parameter int AVG_LOG2     = 6,
  parameter int RATE_W       = 16,
  parameter int POS_W        = 24,
  parameter int DONE_TIMEOUT = 64,
  parameter int LOCK_CNT     = 16
) (
  input  logic              psclk,
  input  logic              reset,
  input  logic              enable,
  input  logic              mode,
  input  logic [3:0]        gain_shift,
  input  logic [ERR_W-1:0]  deadband,
  input  logic [RATE_W-1:0] min_gap,
  input  logic [ERR_W-1:0]  err_in,
  input  logic              err_valid,
  input  logic              clear_err,
  input  logic              psdone,
  output logic              psen,
  output logic              psincdec,
  output logic [POS_W-1:0]  ps_pos,
  output logic [ERR_W-1:0]  avg_out,
  output logic              locked,
  output logic              busy,
  output logic              timeout_err
);
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = ERR_W + AVG_LOG2;
  localparam int TMR_W = $clog2(DONE_TIMEOUT + 1);
  localparam int LCK_W = $clog2(LOCK_CNT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  localparam logic [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};

  logic [ERR_W-1:0]        win_mem [DEPTH];
  logic [AVG_LOG2-1:0]     wptr;
  logic [AVG_LOG2:0]       fill;
  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] err_ext;
  logic signed [SUM_W-1:0] old_ext;
  logic [ERR_W-1:0]        old_val;
  logic                    win_full;
  logic                    sum_vld, sum_full, avg_vld, avg_full;

  assign win_full = (fill == (AVG_LOG2+1)'(DEPTH));
  assign old_val  = win_mem[wptr];
  assign err_ext  = {{AVG_LOG2{err_in[ERR_W-1]}}, err_in};
  assign old_ext  = win_full ? {{AVG_LOG2{old_val[ERR_W-1]}}, old_val} : '0;

  always_ff @(posedge psclk) begin
    if (err_valid) win_mem[wptr] <= err_in;
  end

  // The full flag travels with each sample so an update never acts on a partial window
  always_ff @(posedge psclk) begin
    if (reset) begin
      sum      <= '0;
      wptr     <= '0;
      fill     <= '0;
      sum_vld  <= 1'b0;
      sum_full <= 1'b0;
      avg_vld  <= 1'b0;
      avg_full <= 1'b0;
      avg_out  <= '0;
    end else begin
      sum_vld  <= err_valid;
      avg_vld  <= sum_vld;
      avg_full <= sum_full;
      if (sum_vld) avg_out <= sum[SUM_W-1:AVG_LOG2];
      if (err_valid) begin
        sum      <= sum + err_ext - old_ext;
        wptr     <= wptr + AVG_LOG2'(1);
        sum_full <= (fill >= (AVG_LOG2+1)'(DEPTH - 1));
        if (!win_full) fill <= fill + (AVG_LOG2+1)'(1);
      end
    end
  end

  logic             upd, in_db, avg_neg, dir;
  logic [ERR_W-1:0] mag, shifted;
  logic [7:0]       budget, pending;
  logic [LCK_W-1:0] lock_cnt, lock_next;

  assign upd     = avg_vld && avg_full;
  assign avg_neg = avg_out[ERR_W-1];
  assign mag     = avg_neg ? (~avg_out + ERR_W'(1)) : avg_out;
  assign in_db   = (mag <= deadband);
  assign shifted = mag >> gain_shift;

  always_comb begin
    budget = 8'd1;
    if (mode) begin
      if (shifted > ERR_W'(255)) budget = 8'd255;
      else if (shifted != '0)    budget = shifted[7:0];
    end
  end

  assign lock_next = !in_db ? '0 :
                     (lock_cnt == LCK_W'(LOCK_CNT)) ? lock_cnt : lock_cnt + LCK_W'(1);

  always_ff @(posedge psclk) begin
    if (reset) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
      dir      <= 1'b0;
    end else if (upd) begin
      lock_cnt <= lock_next;
      locked   <= (lock_next == LCK_W'(LOCK_CNT));
      if (!in_db) dir <= avg_neg;
    end
  end

  logic [1:0]        state;
  logic [TMR_W-1:0]  timer;
  logic [RATE_W-1:0] gap_cnt;
  logic              step_done, timeout_hit;

  assign step_done   = (state == S_WAIT) && psdone;
  assign timeout_hit = (state == S_WAIT) && !psdone && (timer == TMR_W'(DONE_TIMEOUT - 1));
  assign busy        = (state != S_IDLE) || (pending != '0);

  // A fresh budget replaces whatever is left, even when a step completes in the same cycle
  always_ff @(posedge psclk) begin
    if (reset)                            pending <= '0;
    else if (!enable)                     pending <= '0;
    else if (upd)                         pending <= in_db ? 8'd0 : budget;
    else if (step_done && pending != '0)  pending <= pending - 8'd1;
    else if (timeout_hit)                 pending <= '0;
  end

  always_ff @(posedge psclk) begin
    if (reset) begin
      state       <= S_IDLE;
      psen        <= 1'b0;
      psincdec    <= 1'b0;
      timer       <= '0;
      gap_cnt     <= '0;
      ps_pos      <= '0;
      timeout_err <= 1'b0;
    end else begin
      psen <= 1'b0;
      if (clear_err) timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable && pending != '0) begin
            state    <= S_REQ;
            psen     <= 1'b1;
            psincdec <= dir;
            timer    <= '0;
          end
        end
        S_REQ: begin
          state <= S_WAIT;
          timer <= timer + TMR_W'(1);
        end
        S_WAIT: begin
          if (psdone) begin
            if (psincdec && ps_pos != POS_MAX)       ps_pos <= ps_pos + POS_W'(1);
            else if (!psincdec && ps_pos != POS_MIN) ps_pos <= ps_pos - POS_W'(1);
            gap_cnt <= '0;
            state   <= S_GAP;
          end else if (timeout_hit) begin
            timeout_err <= 1'b1;
            gap_cnt     <= '0;
            state       <= S_GAP;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: begin
          if (gap_cnt >= min_gap) state <= S_IDLE;
          else                    gap_cnt <= gap_cnt + RATE_W'(1);
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mmcm_ps_servo.sv
// tb/tb_mmcm_ps_servo.sv - scoreboard bench for mmcm_ps_servo
module tb_mmcm_ps_servo;
  localparam int ERR_W  = 16;
  localparam int AVG_L2 = 2;
  localparam int RATE_W = 8;
  localparam int POS_W  = 8;
  localparam int SAT_W  = 4;
  localparam int T_OUT  = 20;
  localparam int LOCK_N = 4;

  logic              psclk = 1'b0, reset = 1'b1, enable = 1'b0, mode = 1'b0;
  logic              err_valid = 1'b0, clear_err = 1'b0;
  logic [3:0]        gain_shift = 4'd0;
  logic [ERR_W-1:0]  deadband = '0, err_in = '0;
  logic [RATE_W-1:0] min_gap = '0;
  logic              resp_done = 1'b0, man_done = 1'b0, psdone;
  logic              psen, psincdec, locked, busy, timeout_err;
  logic [POS_W-1:0]  ps_pos;
  logic [ERR_W-1:0]  avg_out;
  logic              psen_s, psincdec_s, locked_s, busy_s, timeout_err_s;
  logic [SAT_W-1:0]  ps_pos_s;
  logic [ERR_W-1:0]  avg_out_s;

  assign psdone = resp_done | man_done;

  mmcm_ps_servo #(.ERR_W(ERR_W), .AVG_LOG2(AVG_L2), .RATE_W(RATE_W), .POS_W(POS_W),
                  .DONE_TIMEOUT(T_OUT), .LOCK_CNT(LOCK_N)) dut (
    .psclk(psclk), .reset(reset), .enable(enable), .mode(mode), .gain_shift(gain_shift),
    .deadband(deadband), .min_gap(min_gap), .err_in(err_in), .err_valid(err_valid),
    .clear_err(clear_err), .psdone(psdone), .psen(psen), .psincdec(psincdec),
    .ps_pos(ps_pos), .avg_out(avg_out), .locked(locked), .busy(busy), .timeout_err(timeout_err));

  mmcm_ps_servo #(.ERR_W(ERR_W), .AVG_LOG2(AVG_L2), .RATE_W(RATE_W), .POS_W(SAT_W),
                  .DONE_TIMEOUT(T_OUT), .LOCK_CNT(LOCK_N)) dut_sat (
    .psclk(psclk), .reset(reset), .enable(enable), .mode(mode), .gain_shift(gain_shift),
    .deadband(deadband), .min_gap(min_gap), .err_in(err_in), .err_valid(err_valid),
    .clear_err(clear_err), .psdone(psdone), .psen(psen_s), .psincdec(psincdec_s),
    .ps_pos(ps_pos_s), .avg_out(avg_out_s), .locked(locked_s), .busy(busy_s),
    .timeout_err(timeout_err_s));

  always #5 psclk = ~psclk;

  int cyc = 0;
  always @(posedge psclk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d cyc=%0d", name, act, exp, cyc);
    end
  endfunction

  typedef struct { logic dir; int at; } exp_t;
  exp_t exp_q[$];

  task automatic expect_steps(input logic dir, input int first, input int n, input int spacing);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.dir = dir;
      e.at  = first + k * spacing;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge psclk) begin : monitor
    exp_t e;
    if (psen) begin
      if (exp_q.size() == 0) chk("unexpected_psen", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("psen_dir", int'(psincdec), int'(e.dir));
        chk("psen_cycle", cyc, e.at);
        chk("sat_psen_dir", int'(psincdec_s), int'(e.dir));
        chk("sat_psen", int'(psen_s), 1);
      end
    end
  end

  int   resp_lat = 1;
  logic resp_en  = 1'b0;
  initial forever begin
    @(posedge psclk); #1;
    if (psen && resp_en) begin
      repeat (resp_lat) begin @(posedge psclk); #1; end
      resp_done = 1'b1;
      @(posedge psclk); #1;
      resp_done = 1'b0;
    end
  end

  task automatic tick();
    @(posedge psclk); #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  int last_n = 0;
  task automatic send(input int v);
    err_in    = ERR_W'(v);
    err_valid = 1'b1;
    last_n    = cyc;
    tick();
    err_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b1; mode = 1'b0; gain_shift = 4'd0; deadband = '0;
    min_gap = '0; err_valid = 1'b0; clear_err = 1'b0; man_done = 1'b0;
    resp_en = 1'b0; resp_lat = 1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic chk_pos(string name, int pm, int ps);
    chk({name, "_pos"}, int'($signed(ps_pos)), pm);
    chk({name, "_sat_pos"}, int'($signed(ps_pos_s)), ps);
  endtask

  task automatic chk_idle(string name);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_sat_busy"}, int'(busy_s), 0);
    chk({name, "_queue"}, exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  int p, n;
  initial begin
    do_reset();
    chk("rst_psen", int'(psen), 0);
    chk("rst_psincdec", int'(psincdec), 0);
    chk("rst_avg", int'(avg_out), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_timeout", int'(timeout_err), 0);
    chk_pos("rst", 0, 0);

    // window fill: first update only after the fourth sample
    resp_en = 1'b1; resp_lat = 3;
    for (int i = 0; i < 4; i++) send(8);
    p = last_n + 4;
    expect_steps(1'b0, p, 1, 0);
    wait_until(p + 6);
    chk("fill_avg", int'($signed(avg_out)), 8);
    chk("fill_sat_avg", int'($signed(avg_out_s)), 8);
    chk_pos("fill", -1, -1);
    chk_idle("fill");

    // proportional: |-100| >> 3 = 12 increments, spacing lat 3 + gap 5 + 3
    do_reset();
    mode = 1'b1; gain_shift = 4'd3; min_gap = 8'd5; resp_en = 1'b1; resp_lat = 3;
    for (int i = 0; i < 4; i++) send(-100);
    p = last_n + 4;
    expect_steps(1'b1, p, 12, 11);
    wait_until(p + 11 * 11 + 12);
    chk("prop_avg", int'($signed(avg_out)), -100);
    chk_pos("prop", 12, 7);
    chk_idle("prop");

    // lock: deadband 3, steady +2, then +50 breaks lock
    do_reset();
    deadband = 16'd3; resp_en = 1'b1; resp_lat = 1;
    for (int i = 0; i < 6; i++) send(2);
    wait_until(last_n + 5);
    chk("lock_pre", int'(locked), 0);
    chk("lock_avg", int'($signed(avg_out)), 2);
    send(2);
    n = last_n;
    wait_until(n + 2);
    chk("lock_early", int'(locked), 0);
    wait_until(n + 3);
    chk("lock_set", int'(locked), 1);
    chk("lock_sat_set", int'(locked_s), 1);
    send(50);
    n = last_n;
    expect_steps(1'b0, n + 4, 1, 0);
    wait_until(n + 2);
    chk("lock_hold", int'(locked), 1);
    wait_until(n + 3);
    chk("lock_drop", int'(locked), 0);
    chk("lock_avg50", int'($signed(avg_out)), 14);
    wait_until(n + 10);
    chk_pos("lock", -1, -1);
    chk_idle("lock");

    // timeout: no psdone
    do_reset();
    for (int i = 0; i < 4; i++) send(8);
    p = last_n + 4;
    expect_steps(1'b0, p, 1, 0);
    wait_until(p + T_OUT - 1);
    chk("tmo_early", int'(timeout_err), 0);
    wait_until(p + T_OUT);
    chk("tmo_set", int'(timeout_err), 1);
    chk("tmo_sat_set", int'(timeout_err_s), 1);
    chk("tmo_busy_gap", int'(busy), 1);
    wait_until(p + T_OUT + 2);
    chk_pos("tmo", 0, 0);
    chk_idle("tmo");
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    chk("tmo_clear", int'(timeout_err), 0);
    send(8);
    p = last_n + 4;
    expect_steps(1'b0, p, 1, 0);
    clear_err = 1'b1;
    wait_until(p + T_OUT);
    chk("tmo_vs_clear", int'(timeout_err), 1);
    tick();
    chk("tmo_clear2", int'(timeout_err), 0);
    clear_err = 1'b0;
    wait_until(p + T_OUT + 3);
    chk_idle("tmo2");

    // reset during WAIT_DONE, late psdone ignored
    do_reset();
    for (int i = 0; i < 4; i++) send(8);
    p = last_n + 4;
    expect_steps(1'b0, p, 1, 0);
    wait_until(p + 2);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rstmid_psen", int'(psen), 0);
    chk("rstmid_busy", int'(busy), 0);
    tick(); tick();
    man_done = 1'b1; tick(); man_done = 1'b0;
    repeat (4) tick();
    chk_pos("rstmid", 0, 0);
    chk_idle("rstmid");

    // enable dropped mid-budget: only the in-flight step completes
    do_reset();
    mode = 1'b1; gain_shift = 4'd3; min_gap = 8'd5; resp_en = 1'b1; resp_lat = 3;
    for (int i = 0; i < 4; i++) send(-100);
    p = last_n + 4;
    expect_steps(1'b1, p, 1, 0);
    wait_until(p + 1);
    enable = 1'b0;
    wait_until(p + 20);
    chk_pos("en", 1, 1);
    enable = 1'b1;
    repeat (10) tick();
    chk_idle("en");

    // saturation: 10 increments then 20 decrements
    do_reset();
    mode = 1'b1; resp_en = 1'b1; resp_lat = 1;
    for (int i = 0; i < 4; i++) send(-10);
    p = last_n + 4;
    expect_steps(1'b1, p, 10, 4);
    wait_until(p + 9 * 4 + 6);
    chk_pos("sat_up", 10, 7);
    chk_idle("sat_up");
    enable = 1'b0;
    for (int i = 0; i < 3; i++) send(20);
    repeat (4) tick();
    enable = 1'b1;
    send(20);
    p = last_n + 4;
    expect_steps(1'b0, p, 20, 4);
    wait_until(p + 19 * 4 + 6);
    chk_pos("sat_dn", -10, -8);
    chk_idle("sat_dn");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
